// File: rtl/alu_issue_unit_pkg.sv
// Shared constants for the ALU issue unit: widths, instruction field positions,
// opcode encodings, FSM states and the decoded-instruction struct.
package alu_issue_unit_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OPCODE_SIZE = 4;
    localparam int REG_ADDR_W  = 3;
    localparam int IMM_W       = 6;

    // Field layout: [opcode | rd | rs1 | rs2], with imm overlapping rs2 and the low bits
    localparam int OPC_LSB = WORD_SIZE - OPCODE_SIZE;
    localparam int RD_LSB  = OPC_LSB - REG_ADDR_W;
    localparam int RS1_LSB = RD_LSB - REG_ADDR_W;
    localparam int RS2_LSB = RS1_LSB - REG_ADDR_W;

    typedef logic [OPCODE_SIZE-1:0] opcode_t;

    localparam opcode_t OP_NOT  = 4'd0;
    localparam opcode_t OP_AND  = 4'd1;
    localparam opcode_t OP_OR   = 4'd2;
    localparam opcode_t OP_XOR  = 4'd3;
    localparam opcode_t OP_ADD  = 4'd4;
    localparam opcode_t OP_SUB  = 4'd5;
    localparam opcode_t OP_COMP = 4'd6;
    localparam opcode_t OP_LT   = 4'd7;
    localparam opcode_t OP_EQ   = 4'd8;
    localparam opcode_t OP_ANDI = 4'd9;
    localparam opcode_t OP_ADDI = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    typedef struct packed {
        opcode_t                opcode;
        logic [REG_ADDR_W-1:0]  rd;
        logic [REG_ADDR_W-1:0]  rs1;
        logic [REG_ADDR_W-1:0]  rs2;
        logic [WORD_SIZE-1:0]   imm_sext;
        logic                   uses_imm;
    } fields_t;

    function automatic logic is_legal_op(input opcode_t op);
        return op <= OP_ADDI;
    endfunction

endpackage

// File: rtl/alu_issue_unit_instr_field_decode.sv
// Instruction field decoder: splits an instruction word into its fields.
// Purely combinational; no state, no backpressure.
module instr_field_decode
    import alu_issue_unit_pkg::*;
(
    input  logic [WORD_SIZE-1:0] instr,
    output fields_t              fields,
    output logic                 legal
);

    opcode_t op;

    always_comb begin
        op              = instr[OPC_LSB +: OPCODE_SIZE];
        fields.opcode   = op;
        fields.rd       = instr[RD_LSB  +: REG_ADDR_W];
        fields.rs1      = instr[RS1_LSB +: REG_ADDR_W];
        fields.rs2      = instr[RS2_LSB +: REG_ADDR_W];
        fields.imm_sext = {{(WORD_SIZE-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        fields.uses_imm = (op == OP_ANDI) || (op == OP_ADDI);
        legal           = is_legal_op(op);
    end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue/writeback controller, one instruction in flight (IDLE/READ/ISSUE/WB).
// Latency: accept edge -> alu_enable 2 cycles, -> rf_we 3 cycles; 1 instr per 4 cycles.
// Backpressure: instr_ready only in IDLE; ALU_ISSUE_PERF_EN adds the retire counter.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [WORD_SIZE-1:0]    instr,
    output logic [REG_ADDR_W-1:0]   rf_raddr1,
    output logic [REG_ADDR_W-1:0]   rf_raddr2,
    input  logic [WORD_SIZE-1:0]    rf_rdata1,
    input  logic [WORD_SIZE-1:0]    rf_rdata2,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [WORD_SIZE-1:0]    rf_wdata,
    output logic [OPCODE_SIZE-1:0]  alu_opcode,
    output logic [WORD_SIZE-1:0]    alu_input1,
    output logic [WORD_SIZE-1:0]    alu_input2,
    output logic                    alu_enable,
    input  logic [WORD_SIZE-1:0]    alu_result,
    output logic                    done,
    output logic                    illegal_op,
    output logic [15:0]             retire_count
);

    state_e  state_q, state_d;
    fields_t dec;
    logic    dec_legal;
    fields_t fields_q, fields_d;
    logic    illegal_q, illegal_d;
    opcode_t              alu_opcode_q, alu_opcode_d;
    logic [WORD_SIZE-1:0] alu_in1_q, alu_in1_d;
    logic [WORD_SIZE-1:0] alu_in2_q, alu_in2_d;
    logic                 accept;

    instr_field_decode u_decode (
        .instr  (instr),
        .fields (dec),
        .legal  (dec_legal)
    );

    assign accept = instr_valid && (state_q == ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal opcodes are consumed in IDLE and never leave it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && dec_legal) state_d = ST_READ;
            ST_READ:  state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fields_d     = fields_q;
        illegal_d    = accept && !dec_legal;
        alu_opcode_d = alu_opcode_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        if (accept && dec_legal) begin
            fields_d = dec;
        end
        if (state_q == ST_READ) begin
            alu_opcode_d = fields_q.opcode;
            alu_in1_d    = rf_rdata1;
            if (fields_q.uses_imm) begin
                alu_in2_d = fields_q.imm_sext;
            end else if (fields_q.opcode == OP_NOT) begin
                alu_in2_d = '0;
            end else begin
                alu_in2_d = rf_rdata2;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fields_q     <= '0;
            illegal_q    <= 1'b0;
            alu_opcode_q <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
        end else begin
            fields_q     <= fields_d;
            illegal_q    <= illegal_d;
            alu_opcode_q <= alu_opcode_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
        end
    end

    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_enable  = (state_q == ST_ISSUE);
        done        = 1'b0;
        illegal_op  = illegal_q;
        alu_opcode  = alu_opcode_q;
        alu_input1  = alu_in1_q;
        alu_input2  = alu_in2_q;
        if (state_q == ST_READ) begin
            rf_raddr1 = fields_q.rs1;
            rf_raddr2 = fields_q.rs2;
        end
        // r0 is hardwired zero: the write is dropped but the instruction still retires
        if (state_q == ST_WB) begin
            rf_we    = (fields_q.rd != '0);
            rf_waddr = fields_q.rd;
            rf_wdata = alu_result;
            done     = 1'b1;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if (done) begin
            retire_d = retire_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural register file and ALU around the DUT,
// architectural model of the register file for expected writebacks and timing.
module tb_alu_issue_unit;
    import alu_issue_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [15:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic        rf_we;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1, alu_input2;
    logic        alu_enable;
    logic [15:0] alu_result = 16'd0;
    logic        done, illegal_op;
    logic [15:0] retire_count;

    int tests = 0;
    int fails = 0;

    alu_issue_unit dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_enable(alu_enable), .alu_result(alu_result),
        .done(done), .illegal_op(illegal_op), .retire_count(retire_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_COMP: return (a > b) ? 16'd1 : 16'd0;
            OP_LT:   return (a < b) ? 16'd1 : 16'd0;
            OP_EQ:   return (a == b) ? 16'd1 : 16'd0;
            OP_ANDI: return a & b;
            OP_ADDI: return a + b;
            default: return 16'hDEAD;
        endcase
    endfunction

    // Environment: register file and ALU
    logic [15:0] rf [8];
    logic [15:0] mregs [8];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clock) if (rf_we && rf_waddr != 3'd0) rf[rf_waddr] <= rf_wdata;
    always @(posedge clock) if (alu_enable) alu_result <= alu_fn(alu_opcode, alu_input1, alu_input2);

    // Event monitor, sampled on the falling edge
    int cyc = 0;
    int acc_q[$], en_q[$], we_c[$], ill_q[$];
    logic [3:0]  en_op[$];
    logic [15:0] en_a[$], en_b[$], we_d[$];
    logic [2:0]  we_a[$];
    logic        ill_rdy[$];
    int done_n = 0;
    int exp_retire = 0;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (instr_valid && instr_ready) acc_q.push_back(cyc);
            if (alu_enable) begin
                en_q.push_back(cyc); en_op.push_back(alu_opcode);
                en_a.push_back(alu_input1); en_b.push_back(alu_input2);
            end
            if (rf_we) begin
                we_c.push_back(cyc); we_a.push_back(rf_waddr); we_d.push_back(rf_wdata);
            end
            if (done) done_n++;
            if (illegal_op) begin ill_q.push_back(cyc); ill_rdy.push_back(instr_ready); end
        end
    end

    task automatic clear_mon();
        acc_q.delete(); en_q.delete(); en_op.delete(); en_a.delete(); en_b.delete();
        we_c.delete(); we_a.delete(); we_d.delete(); ill_q.delete(); ill_rdy.delete();
        done_n = 0;
    endtask

    task automatic wait_accept(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (acc_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic check_retire(input string tag);
`ifdef ALU_ISSUE_PERF_EN
        tests++; if (retire_count !== 16'(exp_retire)) begin fails++; $display("FAIL %s retire_count got=%0d exp=%0d", tag, retire_count, 16'(exp_retire)); end
`else
        tests++; if (retire_count !== 16'd0) begin fails++; $display("FAIL %s retire_count got=%0d exp=0", tag, retire_count); end
`endif
    endtask

    // One legal instruction: model computes operands/result, monitor gives timing
    task automatic run_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [5:0] low);
        logic [15:0] a, b, res;
        int acc;
        bit ok;
        a = mregs[rs1];
        if (op == OP_ANDI || op == OP_ADDI) b = {{10{low[5]}}, low};
        else if (op == OP_NOT) b = 16'd0;
        else b = mregs[low[5:3]];
        res = alu_fn(op, a, b);
        clear_mon();
        instr = {op, rd, rs1, low};
        instr_valid = 1'b1;
        wait_accept(1, ok);
        instr_valid = 1'b0;
        instr = 16'($urandom);
        repeat (5) @(posedge clock);
        #1;
        tests++; if (!ok) begin fails++; $display("FAIL accept timeout got=none exp=accept"); end
        acc = (acc_q.size() > 0) ? acc_q[0] : 0;
        tests++; if (en_q.size() != 1 || en_q[0] - acc != 2) begin fails++; $display("FAIL enable_timing got=%0d pulses first@+%0d exp=1@+2", en_q.size(), (en_q.size() > 0) ? en_q[0] - acc : -1); end
        tests++; if (en_op.size() > 0 && en_op[0] !== op) begin fails++; $display("FAIL alu_opcode got=%0d exp=%0d", en_op[0], op); end
        tests++; if (en_a.size() > 0 && en_a[0] !== a) begin fails++; $display("FAIL alu_input1 got=%0h exp=%0h", en_a[0], a); end
        tests++; if (en_b.size() > 0 && en_b[0] !== b) begin fails++; $display("FAIL alu_input2 got=%0h exp=%0h", en_b[0], b); end
        tests++; if (we_c.size() != ((rd != 3'd0) ? 1 : 0)) begin fails++; $display("FAIL rf_we_count got=%0d exp=%0d", we_c.size(), (rd != 3'd0) ? 1 : 0); end
        if (we_c.size() > 0) begin
            tests++; if (we_c[0] - acc != 3) begin fails++; $display("FAIL rf_we_timing got=+%0d exp=+3", we_c[0] - acc); end
            tests++; if (we_a[0] !== rd) begin fails++; $display("FAIL rf_waddr got=%0d exp=%0d", we_a[0], rd); end
            tests++; if (we_d[0] !== res) begin fails++; $display("FAIL rf_wdata got=%0h exp=%0h", we_d[0], res); end
        end
        tests++; if (done_n != 1) begin fails++; $display("FAIL done_count got=%0d exp=1", done_n); end
        tests++; if (ill_q.size() != 0) begin fails++; $display("FAIL spurious_illegal got=%0d exp=0", ill_q.size()); end
        if (rd != 3'd0) mregs[rd] = res;
        exp_retire++;
        check_retire("run_instr");
    endtask

    task automatic test_reset();
        tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset instr_ready got=%b exp=1", instr_ready); end
        tests++; if ({alu_enable, rf_we, done, illegal_op} !== 4'b0) begin fails++; $display("FAIL reset strobes got=%b exp=0000", {alu_enable, rf_we, done, illegal_op}); end
        tests++; if ({alu_opcode, alu_input1, alu_input2} !== 36'd0) begin fails++; $display("FAIL reset alu_outputs got=%0h exp=0", {alu_opcode, alu_input1, alu_input2}); end
        tests++; if ({rf_raddr1, rf_raddr2, rf_waddr, rf_wdata} !== 25'd0) begin fails++; $display("FAIL reset rf_outputs got=%0h exp=0", {rf_raddr1, rf_raddr2, rf_waddr, rf_wdata}); end
        tests++; if (retire_count !== 16'd0) begin fails++; $display("FAIL reset retire_count got=%0d exp=0", retire_count); end
    endtask

    task automatic test_add();
        run_instr(OP_ADD, 3'd3, 3'd1, {3'd2, 3'd0});
        tests++; if (we_d.size() == 0 || we_d[0] !== 16'd12) begin fails++; $display("FAIL add_directed got=%0h exp=c", (we_d.size() > 0) ? we_d[0] : 16'hxxxx); end
    endtask

    task automatic test_addi();
        run_instr(OP_ADDI, 3'd4, 3'd1, 6'h3F);
        tests++; if (en_b.size() == 0 || en_b[0] !== 16'hFFFF) begin fails++; $display("FAIL addi_imm got=%0h exp=ffff", (en_b.size() > 0) ? en_b[0] : 16'hxxxx); end
        tests++; if (we_d.size() == 0 || we_d[0] !== 16'h0004) begin fails++; $display("FAIL addi_result got=%0h exp=4", (we_d.size() > 0) ? we_d[0] : 16'hxxxx); end
    endtask

    task automatic test_illegal();
        bit ok;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            instr = {4'(11 + $urandom_range(0, 4)), 12'($urandom)};
            instr_valid = 1'b1;
            wait_accept(1, ok);
            instr_valid = 1'b0;
            repeat (5) @(posedge clock);
            #1;
            tests++; if (!ok) begin fails++; $display("FAIL illegal accept timeout got=none exp=accept"); end
            tests++; if (ill_q.size() != 1 || ill_q[0] - acc_q[0] != 1) begin fails++; $display("FAIL illegal_pulse got=%0d pulses exp=1@+1", ill_q.size()); end
            tests++; if (ill_rdy.size() > 0 && ill_rdy[0] !== 1'b1) begin fails++; $display("FAIL illegal instr_ready got=%b exp=1", ill_rdy[0]); end
            tests++; if (en_q.size() + we_c.size() + done_n != 0) begin fails++; $display("FAIL illegal activity got=%0d exp=0", en_q.size() + we_c.size() + done_n); end
            check_retire("illegal");
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  rd [2], rs1 [2], rs2 [2];
        logic [15:0] res [2];
        bit ok1, ok2;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 3'($urandom_range(1, 7)); rs1[k] = 3'($urandom); rs2[k] = 3'($urandom);
        end
        clear_mon();
        instr = {OP_ADD, rd[0], rs1[0], rs2[0], 3'd0};
        instr_valid = 1'b1;
        wait_accept(1, ok1);
        instr = {OP_ADD, rd[1], rs1[1], rs2[1], 3'd0};
        wait_accept(2, ok2);
        instr_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        res[0] = mregs[rs1[0]] + mregs[rs2[0]]; mregs[rd[0]] = res[0];
        res[1] = mregs[rs1[1]] + mregs[rs2[1]]; mregs[rd[1]] = res[1];
        exp_retire += 2;
        tests++; if (!(ok1 && ok2)) begin fails++; $display("FAIL b2b accept timeout got=%0d exp=2", acc_q.size()); end
        tests++; if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 4) begin fails++; $display("FAIL b2b spacing got=%0d exp=4", (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1); end
        tests++; if (done_n != 2) begin fails++; $display("FAIL b2b done_count got=%0d exp=2", done_n); end
        tests++; if (we_c.size() != 2) begin fails++; $display("FAIL b2b we_count got=%0d exp=2", we_c.size()); end
        for (int k = 0; k < 2 && k < we_c.size(); k++) begin
            tests++; if (we_a[k] !== rd[k] || we_d[k] !== res[k]) begin fails++; $display("FAIL b2b write%0d got=r%0d=%0h exp=r%0d=%0h", k, we_a[k], we_d[k], rd[k], res[k]); end
        end
        check_retire("b2b");
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        instr = {OP_ADD, 3'd5, 3'd1, 3'd2, 3'd0};
        instr_valid = 1'b1;
        wait_accept(1, ok);
        instr_valid = 1'b0;
        @(posedge clock); #1;
        tests++; if (alu_enable !== 1'b1) begin fails++; $display("FAIL midreset in_issue got=%b exp=1", alu_enable); end
        reset = 1'b1;
        #1;
        tests++; if ({alu_enable, rf_we, done, illegal_op, instr_ready} !== 5'b00001) begin fails++; $display("FAIL midreset strobes got=%b exp=00001", {alu_enable, rf_we, done, illegal_op, instr_ready}); end
        tests++; if ({alu_opcode, alu_input1, alu_input2} !== 36'd0) begin fails++; $display("FAIL midreset alu_outputs got=%0h exp=0", {alu_opcode, alu_input1, alu_input2}); end
        exp_retire = 0;
        check_retire("midreset");
        @(negedge clock); reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        tests++; if (we_c.size() + done_n != 0) begin fails++; $display("FAIL midreset dropped_write got=%0d exp=0", we_c.size() + done_n); end
        run_instr(OP_SUB, 3'd6, 3'd2, {3'd1, 3'd0});
    endtask

    task automatic test_r0();
        run_instr(OP_XOR, 3'd0, 3'd1, {3'd2, 3'd0});
        tests++; if (rf[0] !== 16'd0) begin fails++; $display("FAIL r0 got=%0h exp=0", rf[0]); end
    endtask

    task automatic test_random(input int n);
        for (int k = 0; k < n; k++) begin
            run_instr(4'($urandom_range(0, 10)), 3'($urandom), 3'($urandom), 6'($urandom));
        end
        for (int r = 0; r < 8; r++) begin
            tests++; if (rf[r] !== mregs[r]) begin fails++; $display("FAIL regfile r%0d got=%0h exp=%0h", r, rf[r], mregs[r]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 16'd0;
        for (int r = 0; r < 8; r++) begin
            mregs[r] = (r == 0) ? 16'd0 : 16'($urandom);
        end
        mregs[1] = 16'd5;
        mregs[2] = 16'd7;
        for (int r = 0; r < 8; r++) rf[r] = mregs[r];
        #12;
        test_reset();
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        test_add();
        test_addi();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_r0();
        test_random(30);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Issue/writeback controller that drives the ALU's input side: opcode, operands and enable.
- Accepts instruction words from fetch over a valid/ready handshake.
- Reads operands from the register file, issues exactly one ALU enable pulse per legal instruction, and writes the registered ALU result back to the register file.
- Sits between fetch/regfile and the ALU; one instruction in flight at a time.

Parameters:
- WORD_SIZE, 16, data and instruction width.
- OPCODE_SIZE, 4, opcode field width; instr[WORD_SIZE-1 -: OPCODE_SIZE].
- REG_ADDR_W, 3, register address width (8 registers).
- IMM_W, 6, immediate field width; instr[IMM_W-1:0], sign-extended.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  fetch offers an instruction.
- instr_ready  out  1  unit can accept; high only in IDLE.
- instr  in  WORD_SIZE  fields: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm.
- rf_raddr1  out  REG_ADDR_W  read address for operand 1 (rs1).
- rf_raddr2  out  REG_ADDR_W  read address for operand 2 (rs2).
- rf_rdata1  in  WORD_SIZE  combinational read data for rf_raddr1.
- rf_rdata2  in  WORD_SIZE  combinational read data for rf_raddr2.
- rf_we  out  1  register write strobe.
- rf_waddr  out  REG_ADDR_W  write address (rd).
- rf_wdata  out  WORD_SIZE  write data.
- alu_opcode  out  OPCODE_SIZE  opcode to the ALU.
- alu_input1  out  WORD_SIZE  ALU operand 1.
- alu_input2  out  WORD_SIZE  ALU operand 2.
- alu_enable  out  1  ALU capture enable.
- alu_result  in  WORD_SIZE  ALU output, registered by the ALU on the clock edge where alu_enable=1.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an opcode is rejected.
- retire_count  out  16  retired-instruction count (see Optional Feature).

Behaviour:
- Interface: one clock, `clock`; reset is asynchronous and active-high, `reset`.
- Reset forces state IDLE and drives every output to 0, except instr_ready, which is 1.
  - Reset mid-operation drops the in-flight instruction; no rf_we is issued for it.
- Opcode encoding (shared constants): NOT=0, AND=1, OR=2, XOR=3, ADD=4, SUB=5, COMP=6, LT=7, EQ=8, ANDI=9, ADDI=10. Opcodes 11-15 are illegal.
- FSM states: IDLE, READ, ISSUE, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, register instr -> READ.
  - Illegal opcode: illegal_op=1 for the next cycle, return to IDLE, no ALU or regfile activity.
- READ:
  - rf_raddr1=rs1, rf_raddr2=rs2.
  - At the clock edge, register alu_opcode, alu_input1 and alu_input2 -> ISSUE.
  - alu_input1=rf_rdata1 for all legal opcodes.
  - alu_input2 for ANDI/ADDI: imm sign-extended to WORD_SIZE; rs2 ignored.
  - alu_input2 for NOT: 0.
  - alu_input2 otherwise: rf_rdata2.
- ISSUE:
  - alu_enable=1 for exactly this cycle; operands held stable -> WB.
- WB:
  - rf_we=1, rf_waddr=rd, rf_wdata=alu_result, done=1 -> IDLE.
  - rd==0: rf_we is suppressed (r0 is hardwired zero); done still pulses.
- Latency: accept edge to rf_we high is 3 cycles; throughput is 1 instruction per 4 cycles. alu_enable and rf_we are never high outside ISSUE and WB.
- Backpressure: instr_ready=0 in READ/ISSUE/WB. A held instr_valid is accepted on the first IDLE cycle after WB. No instruction is lost or duplicated.
- Arithmetic: all widths are WORD_SIZE; no carry or flags are produced. COMP/LT/EQ results are written as returned by the ALU.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- Defined: retire_count is a 16-bit counter, reset to 0.
  - Increments on each done pulse, including rd==0 retirements.
  - Excludes illegal_op events.
  - Wraps 0xFFFF -> 0x0000.
- Undefined: retire_count is tied to 0 and no counter logic is present.

Decomposition:
- Shared header parameters.vh holds:
  - opcode constants;
  - WORD_SIZE, OPCODE_SIZE, REG_ADDR_W, IMM_W;
  - instruction field bit positions;
  - FSM state encodings.
- Sub-module instr_field_decode (combinational) handles:
  - opcode/rd/rs1/rs2 extraction;
  - imm sign extension;
  - legal-opcode check;
  - uses_imm flag.

Test Plan:
- ADD r3,r1,r2 with r1=5, r2=7 -> alu_enable high 2 cycles after accept, rf_we=1, rf_waddr=3, rf_wdata=12 at 3 cycles, done=1.
- ADDI r4,r1,imm=6'h3F with r1=5 -> alu_input2=16'hFFFF, rf_wdata=16'h0004.
- instr opcode=4'hF -> illegal_op pulse 1 cycle after accept; alu_enable and rf_we never high; instr_ready back to 1 next cycle.
- instr_valid held high for two back-to-back ADDs -> second accepted exactly 4 cycles after the first; two done pulses; retire_count=2 with ALU_ISSUE_PERF_EN.
- reset asserted during ISSUE -> all outputs 0 asynchronously, instr_ready=1, no rf_we; next instruction completes normally.
- XOR r0,r1,r2 -> done pulses, rf_we stays 0.
